// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } rx_state_e;

   // Smallest usable bit period; below this the mid-bit sample point collapses.
   localparam int unsigned MIN_DIV   = 4;
   localparam int unsigned FRAME_W   = 8;
   localparam int unsigned BIT_IDX_W = $clog2(FRAME_W);

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO with flush; a pop frees a slot for a push in the same cycle.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     clr_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     valid_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q;
   logic [PTR_W-1:0] rptr_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             valid_q;
   logic             full;
   logic             pop_ok;
   logic             push_ok;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign pop_ok  = pop_i & valid_q;
   assign push_ok = push_i & (~full | pop_ok);

   // Next occupancy; a flush overrides any push or pop.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (push_ok && !pop_ok) begin
         count_d = count_q + CNT_W'(1);
      end else if (!push_ok && pop_ok) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
      end else if (clr_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
      end else begin
         if (push_ok) begin
            mem_q[wptr_q] <= data_i;
            wptr_q        <= wptr_q + PTR_W'(1);
         end
         if (pop_ok) begin
            rptr_q <= rptr_q + PTR_W'(1);
         end
         count_q <= count_d;
         valid_q <= (count_d != '0);
      end
   end

   assign data_o  = mem_q[rptr_q];
   assign valid_o = valid_q;
   assign full_o  = full;
   assign count_o = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a byte FIFO, with sticky frame-error and overrun flags.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned DIV_W = 32
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   input  logic                   ser_rx,
   input  logic                   enable_i,
   input  logic [DIV_W-1:0]       div_i,
   input  logic                   clr_i,
   output logic [7:0]             rx_data_o,
   output logic                   rx_valid_o,
   input  logic                   rx_ready_i,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   frame_err_o,
   output logic                   overrun_o
);

   logic [1:0]           sync_q;
   logic                 rx_prev_q;
   logic                 rx_s;
   logic                 fall_c;
   logic [DIV_W-1:0]     eff_div_c;

   rx_state_e            state_q;
   logic [DIV_W-1:0]     div_q;
   logic [DIV_W-1:0]     timer_q;
   logic [BIT_IDX_W-1:0] bit_q;
   logic [FRAME_W-1:0]   shift_q;
   logic                 push_q;
   logic                 ferr_q;
   logic                 frame_err_q;
   logic                 overrun_q;

   logic                 fifo_valid;
   logic                 fifo_full;

   assign rx_s      = sync_q[1];
   assign fall_c    = rx_prev_q & ~rx_s;
   assign eff_div_c = (div_i < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div_i;

   // Two-flop synchronizer plus one history flop for falling-edge detection; idle high.
   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         sync_q    <= 2'b11;
         rx_prev_q <= 1'b1;
      end else begin
         sync_q    <= {sync_q[0], ser_rx};
         rx_prev_q <= sync_q[1];
      end
   end

   // Deserializer: divider is captured at the start edge, so mid-frame div_i changes are ignored.
   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state_q <= ST_IDLE;
         div_q   <= DIV_W'(MIN_DIV);
         timer_q <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         push_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         push_q <= 1'b0;
         ferr_q <= 1'b0;
         if (!enable_i) begin
            state_q <= ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (fall_c) begin
                     state_q <= ST_START;
                     div_q   <= eff_div_c;
                     timer_q <= (eff_div_c >> 1) - DIV_W'(1);
                  end
               end
               ST_START: begin
                  if (timer_q == '0) begin
                     if (!rx_s) begin
                        state_q <= ST_DATA;
                        timer_q <= div_q - DIV_W'(1);
                        bit_q   <= '0;
                     end else begin
                        state_q <= ST_IDLE;
                     end
                  end else begin
                     timer_q <= timer_q - DIV_W'(1);
                  end
               end
               ST_DATA: begin
                  if (timer_q == '0) begin
                     shift_q <= {rx_s, shift_q[FRAME_W-1:1]};
                     timer_q <= div_q - DIV_W'(1);
                     if (bit_q == BIT_IDX_W'(FRAME_W - 1)) begin
                        state_q <= ST_STOP;
                     end else begin
                        bit_q <= bit_q + BIT_IDX_W'(1);
                     end
                  end else begin
                     timer_q <= timer_q - DIV_W'(1);
                  end
               end
               ST_STOP: begin
                  if (timer_q == '0) begin
                     state_q <= ST_IDLE;
                     if (rx_s) begin
                        push_q <= 1'b1;
                     end else begin
                        ferr_q <= 1'b1;
                     end
                  end else begin
                     timer_q <= timer_q - DIV_W'(1);
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   // Sticky status; a clear in the same cycle as a set leaves the flag low.
   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else if (clr_i) begin
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         frame_err_q <= frame_err_q | ferr_q;
         overrun_q   <= overrun_q | (push_q & fifo_full & ~(rx_ready_i & fifo_valid));
      end
   end

   sync_fifo #(
      .WIDTH (FRAME_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (wb_clk_i),
      .rst_ni  (wb_rst_i),
      .clr_i   (clr_i),
      .push_i  (push_q),
      .data_i  (shift_q),
      .pop_i   (rx_ready_i),
      .data_o  (rx_data_o),
      .valid_o (fifo_valid),
      .full_o  (fifo_full),
      .count_o (count_o)
   );

   assign rx_valid_o  = fifo_valid;
   assign frame_err_o = frame_err_q;
   assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scenario bench for uart_rx_fifo: serial frames in, FIFO bytes checked against a queue.
module tb_uart_rx_fifo;
   import uart_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ser_rx;
   logic        enable;
   logic [31:0] div;
   logic        clr;
   logic        ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [3:0]  count;
   logic        frame_err;
   logic        overrun;

   int          errors = 0;
   int          checks = 0;
   logic [7:0]  exp_q[$];

   always #5 clk = ~clk;

   uart_rx_fifo #(.DEPTH(8), .DIV_W(32)) dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst_n),
      .ser_rx      (ser_rx),
      .enable_i    (enable),
      .div_i       (div),
      .clr_i       (clr),
      .rx_data_o   (rx_data),
      .rx_valid_o  (rx_valid),
      .rx_ready_i  (ready),
      .count_o     (count),
      .frame_err_o (frame_err),
      .overrun_o   (overrun)
   );

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives one 8N1 frame, each bit held 'period' cycles; first line change at posedge+1.
   task automatic send_frame(input logic [7:0] data, input int period, input logic stop_bit);
      @(posedge clk); #1;
      ser_rx = 1'b0;
      repeat (period) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         ser_rx = data[i];
         repeat (period) @(posedge clk);
         #1;
      end
      ser_rx = stop_bit;
      repeat (period) @(posedge clk);
      #1;
      ser_rx = 1'b1;
   endtask

   // Pops everything out and compares against the scoreboard, then checks nothing is missing.
   task automatic drain(input string name);
      logic [7:0] exp;
      int guard = 0;
      @(posedge clk); #1;
      ready = 1'b1;
      while (guard < 40) begin
         @(negedge clk);
         if (!rx_valid) break;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected byte got=%02h", name, rx_data);
         end else begin
            exp = exp_q.pop_front();
            if (rx_data !== exp) begin
               errors++;
               $display("FAIL %s: data got=%02h exp=%02h", name, rx_data, exp);
            end
         end
         guard++;
      end
      @(posedge clk); #1;
      ready = 1'b0;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: missing bytes got=0 exp=%0d", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ser_rx = 1'b1; enable = 1'b1; div = 32'd8;
      clr = 1'b0; ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (count !== 4'd0)     begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (rx_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
      checks++; if (rx_data !== 8'h00)  begin errors++; $display("FAIL reset_data got=%02h exp=00", rx_data); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
      checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL reset_ovr got=%b exp=0", overrun); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(4);
   endtask

   task automatic test_basic();
      bit found = 0;
      div = 32'd8;
      exp_q.push_back(8'hA5);
      fork
         send_frame(8'hA5, 8, 1'b1);
         begin
            @(posedge clk); #1;
            for (int c = 0; c < 84; c++) begin
               @(negedge clk);
               if (rx_valid) begin found = 1; break; end
            end
         end
      join
      checks++; if (!found) begin errors++; $display("FAIL basic_latency got=timeout exp=valid within 84"); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL basic_ferr got=%b exp=0", frame_err); end
      drain("basic");
      // Divider below the minimum is clamped to 4.
      div = 32'd2;
      exp_q.push_back(8'h3F);
      send_frame(8'h3F, 4, 1'b1);
      idle(8);
      drain("clamp");
      div = 32'd8;
      idle(4);
   endtask

   task automatic test_glitch();
      div = 32'd8;
      @(posedge clk); #1;
      ser_rx = 1'b0;
      idle(2);
      ser_rx = 1'b1;
      idle(20);
      @(negedge clk);
      checks++; if (count !== 4'd0) begin errors++; $display("FAIL glitch_count got=%0d exp=0", count); end
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid got=%b exp=0", rx_valid); end
      checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL glitch_state got=%0d exp=0", dut.state_q); end
      idle(2);
   endtask

   task automatic test_frame_err();
      div = 32'd16;
      send_frame(8'h3C, 16, 1'b0);
      idle(16);
      @(negedge clk);
      checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_set got=%b exp=1", frame_err); end
      checks++; if (count !== 4'd0)     begin errors++; $display("FAIL ferr_count got=%0d exp=0", count); end
      @(posedge clk); #1; clr = 1'b1;
      @(posedge clk); #1; clr = 1'b0;
      @(negedge clk);
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clr got=%b exp=0", frame_err); end
      div = 32'd8;
      idle(2);
   endtask

   task automatic test_enable();
      fork
         send_frame(8'h5A, 8, 1'b1);
         begin
            @(posedge clk); #1;
            repeat (24) @(posedge clk);
            #1 enable = 1'b0;
         end
      join
      idle(8);
      enable = 1'b1;
      idle(8);
      @(negedge clk);
      checks++; if (count !== 4'd0) begin errors++; $display("FAIL enable_count got=%0d exp=0", count); end
      idle(2);
   endtask

   task automatic test_overrun();
      bit exp_ovr = 0;
      for (int b = 0; b < 9; b++) begin
         if (exp_q.size() < 8) exp_q.push_back(8'(b));
         else exp_ovr = 1;
         send_frame(8'(b), 8, 1'b1);
         idle(4);
      end
      @(negedge clk);
      checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovr_count got=%0d exp=8", count); end
      checks++; if (overrun !== exp_ovr) begin errors++; $display("FAIL ovr_flag got=%b exp=%b", overrun, exp_ovr); end
      drain("overrun");
      @(posedge clk); #1; clr = 1'b1;
      @(posedge clk); #1; clr = 1'b0;
      @(negedge clk);
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr got=%b exp=0", overrun); end
      idle(2);
   endtask

   task automatic test_full_push_pop();
      logic [7:0] exp;
      for (int b = 0; b < 8; b++) begin
         exp_q.push_back(8'(8'h10 + b));
         send_frame(8'(8'h10 + b), 8, 1'b1);
         idle(4);
      end
      exp_q.push_back(8'h18);
      fork
         send_frame(8'h18, 8, 1'b1);
         begin
            @(posedge clk); #1;
            repeat (79) @(posedge clk);
            #1 ready = 1'b1;
            @(negedge clk);
            exp = exp_q.pop_front();
            checks++; if (rx_data !== exp) begin errors++; $display("FAIL fullpp_head got=%02h exp=%02h", rx_data, exp); end
            @(posedge clk); #1 ready = 1'b0;
         end
      join
      idle(4);
      @(negedge clk);
      checks++; if (count !== 4'd8) begin errors++; $display("FAIL fullpp_count got=%0d exp=8", count); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL fullpp_ovr got=%b exp=0", overrun); end
      drain("full_push_pop");
   endtask

   task automatic test_reset_mid();
      fork
         send_frame(8'hFF, 8, 1'b1);
         begin
            @(posedge clk); #1;
            repeat (42) @(posedge clk);
            #1 rst_n = 1'b0;
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;
         end
      join
      idle(16);
      @(negedge clk);
      checks++; if (count !== 4'd0) begin errors++; $display("FAIL rstmid_count got=%0d exp=0", count); end
      exp_q.push_back(8'h12);
      send_frame(8'h12, 8, 1'b1);
      idle(8);
      drain("reset_mid");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_frame_err();
      test_enable();
      test_overrun();
      test_full_push_pop();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
